// File: rtl/rv32i_types_pkg.sv
// Shared RV32I pipeline types: machine word and the hazard sequencer state encoding.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hazard_state_t;

  localparam word_t WORD_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/execute_hazard_if.sv
// Control bundle between the execute stage and the hazard sequencer.
interface execute_hazard_if;
  import rv32i_types_pkg::*;

  logic  dwait;
  logic  branch_mispredict;
  word_t branch_jump_addr;
  logic  flush;
  logic  stall;

  modport hazard (
    input  dwait, branch_mispredict, branch_jump_addr,
    output flush, stall
  );

  modport execute (
    output dwait, branch_mispredict, branch_jump_addr,
    input  flush, stall
  );

endinterface

// File: rtl/sat_counter.sv
// 32-bit event counter that sticks at all-ones; clear wins over increment.
module sat_counter
  import rv32i_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] count
);

  word_t count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != WORD_MAX)) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_sequencer.sv
// Turns execute-stage stalls and mispredicts into fetch/execute flush, stall and
// PC-redirect controls, deferring the redirect while an instruction fetch is in flight.
module hazard_sequencer
  import rv32i_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ex_dwait,
  input  logic        ex_branch_mispredict,
  input  logic [31:0] ex_branch_jump_addr,
  input  logic        if_iwait,
  input  logic        cnt_clr,
  output logic        ex_flush,
  output logic        ex_stall,
  output logic        if_flush,
  output logic        if_stall,
  output logic        pc_load,
  output logic [31:0] pc_load_addr,
  output logic        redirect_pending,
  output logic [31:0] stall_cnt,
  output logic [31:0] redirect_cnt
);

  execute_hazard_if ex_if ();

  hazard_state_t state;
  hazard_state_t next_state;
  word_t         tgt_q;
  logic          mp;
  logic          capture;
  logic          flush_c;
  logic          stall_c;

  assign ex_if.dwait             = ex_dwait;
  assign ex_if.branch_mispredict = ex_branch_mispredict;
  assign ex_if.branch_jump_addr  = ex_branch_jump_addr;
  assign ex_if.flush             = flush_c;
  assign ex_if.stall             = stall_c;
  assign ex_flush                = ex_if.flush;
  assign ex_stall                = ex_if.stall;

  // A mispredict is only trusted once the execute stage has its data.
  assign mp = ex_if.branch_mispredict & ~ex_if.dwait;

  always_comb begin
    next_state   = state;
    flush_c      = 1'b0;
    stall_c      = 1'b0;
    if_flush     = 1'b0;
    if_stall     = 1'b0;
    pc_load      = 1'b0;
    capture      = 1'b0;
    pc_load_addr = (state == WAIT) ? tgt_q : ex_if.branch_jump_addr;
    case (state)
      RUN: begin
        if (ex_if.dwait) begin
          stall_c  = 1'b1;
          if_stall = 1'b1;
        end else if (mp && !if_iwait) begin
          pc_load  = 1'b1;
          if_flush = 1'b1;
          flush_c  = 1'b1;
        end else if (mp) begin
          capture    = 1'b1;
          flush_c    = 1'b1;
          if_stall   = 1'b1;
          next_state = WAIT;
        end else if (if_iwait) begin
          flush_c = 1'b1;
        end
      end
      WAIT: begin
        flush_c = 1'b1;
        if (if_iwait) begin
          if_stall = 1'b1;
        end else begin
          pc_load    = 1'b1;
          if_flush   = 1'b1;
          next_state = RUN;
        end
      end
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      tgt_q <= '0;
    end else begin
      state <= next_state;
      if (capture) begin
        tgt_q <= ex_if.branch_jump_addr;
      end
    end
  end

  assign redirect_pending = (state == WAIT);

  sat_counter u_stall_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (ex_stall),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  sat_counter u_redirect_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (pc_load),
    .clr   (cnt_clr),
    .count (redirect_cnt)
  );

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Interface SHALL have one clock and reset; reset is asynchronous and active-low.
REQ-002 CLK  input  1  pipeline clock; all state updates on rising edge.
REQ-003 nRST  input  1  asynchronous active-low reset.
REQ-004 ex_dwait  input  1  execute stage waiting on data memory.
REQ-005 ex_branch_mispredict  input  1  resolved branch/jump in execute was mispredicted.
REQ-006 ex_branch_jump_addr  input  32 (word_t)  correct target for mispredict.
REQ-007 if_iwait  input  1  fetch stage has an instruction-memory access in flight.
REQ-008 cnt_clr  input  1  synchronous clear of both counters.
REQ-009 ex_flush  output  1  bubble the execute pipeline register.
REQ-010 ex_stall  output  1  hold the execute pipeline register.
REQ-011 if_flush  output  1  discard fetch-stage wrong-path state.
REQ-012 if_stall  output  1  hold fetch PC and request.
REQ-013 pc_load  output  1  one-cycle pulse: fetch PC <= pc_load_addr.
REQ-014 pc_load_addr  output  32  redirect target.
REQ-015 redirect_pending  output  1  high while in state WAIT.
REQ-016 stall_cnt  output  32  saturating count of cycles with ex_stall=1.
REQ-017 redirect_cnt  output  32  saturating count of pc_load pulses.

Function
REQ-018 FSM SHALL have two states: RUN, WAIT; outputs combinational from state and inputs.
REQ-019 Qualified mispredict mp = ex_branch_mispredict & ~ex_dwait; mispredict during dwait SHALL be ignored until dwait falls.
REQ-020 RUN, ex_dwait=1: ex_stall=1, if_stall=1, ex_flush=0, pc_load=0; stall dominates all other RUN conditions.
REQ-021 RUN, mp=1, if_iwait=0: pc_load=1, pc_load_addr=ex_branch_jump_addr, if_flush=1, ex_flush=1 same cycle; stay RUN.
REQ-022 RUN, mp=1, if_iwait=1: capture ex_branch_jump_addr into tgt_q, ex_flush=1, if_stall=1, pc_load=0; next state WAIT.
REQ-023 RUN, no mp, ex_dwait=0, if_iwait=1: ex_flush=1 (bubble), if_stall=0.
REQ-024 RUN, all inputs low: all control outputs 0.
REQ-025 WAIT, if_iwait=1: ex_flush=1, if_stall=1, pc_load=0; ex_dwait and ex_branch_mispredict SHALL be ignored.
REQ-026 WAIT, if_iwait=0: pc_load=1, pc_load_addr=tgt_q, if_flush=1, ex_flush=1; next state RUN.
REQ-027 pc_load_addr SHALL equal tgt_q in WAIT, else ex_branch_jump_addr.
REQ-028 Redirect latency: 0 cycles from mp when fetch idle; from iwait fall when pending; exactly one pc_load per accepted mispredict.
REQ-029 stall_cnt increments by 1 each cycle ex_stall=1; redirect_cnt increments by 1 each pc_load cycle; both saturate at 0xFFFF_FFFF (no wrap).
REQ-030 cnt_clr=1 SHALL zero both counters next edge, overriding same-cycle increment.

Reset
REQ-031 nRST low SHALL force state RUN, tgt_q=0, stall_cnt=0, redirect_cnt=0 immediately, independent of CLK.
REQ-032 Reset asserted in WAIT SHALL discard the pending redirect; no pc_load after release.
REQ-033 After reset with inputs low, all outputs SHALL be 0.

Structure
REQ-034 word_t SHALL come from rv32i_types_pkg; state enum hazard_state_t (RUN, WAIT) SHALL be added to rv32i_types_pkg.
REQ-035 One sub-module sat_counter (32-bit, inc, clr, async reset) SHALL be instantiated twice for the counters.
REQ-036 Execute-side ports SHALL map onto execute_hazard_if hazard modport (dwait, branch_mispredict, branch_jump_addr in; flush, stall out).

Verification
REQ-037 Idle fetch: mp with target 0x0000_0200 -> same-cycle pc_load=1, pc_load_addr=0x200, if_flush=ex_flush=1; redirect_cnt=1.
REQ-038 Busy fetch: mp target 0x0000_0400, iwait high 3 more cycles -> WAIT 3 cycles with ex_flush=1, then single pc_load with 0x400 while branch_jump_addr driven to 0xDEAD_BEEF.
REQ-039 dwait=1 for 4 cycles with mispredict high -> ex_stall=if_stall=1 for 4 cycles, no pc_load until dwait falls, stall_cnt=4.
REQ-040 nRST pulsed mid-WAIT -> state RUN, counters 0, no pc_load after release.
REQ-041 Preload stall_cnt to 0xFFFF_FFFE, stall 3 cycles -> holds 0xFFFF_FFFF; cnt_clr with ex_stall=1 -> 0 next cycle.
